qarma_result_fifo: RTL and testbench

Result buffer between the iterative QARMA cipher core and the QarmaControl Wishbone slave. It captures each finished 64-bit cipher output together with its job tag, holds up to DEPTH results in order, and presents the oldest one to the control block, which reads it and then pops it. It also keeps sticky overflow/underflow flags and can raise a level-threshold interrupt for the caravel `irq` line.

---
 rtl/qarma_result_fifo.sv | 134 +++++++++++++
 tb/tb_qarma_result_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/qarma_result_fifo.sv
// rtl/qarma_result_fifo.sv - in-order result buffer between the QARMA core and its Wishbone control slave
// Optional threshold interrupt built only when QARMA_RESULT_IRQ_EN is defined.
module qarma_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              in_ready_o,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic              clr_i,
    input  logic [LW-1:0]     thresh_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [LW-1:0]     level_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              irq_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = TAG_W + DATA_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full, empty;
    logic push_en, pop_en;
    logic ovf_evt, udf_evt;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);

    // A pop on a full FIFO frees the slot the concurrent push writes into.
    assign push_en = in_valid_i && (!full || pop_i) && !flush_i;
    assign pop_en  = pop_i && !empty && !flush_i;
    assign ovf_evt = in_valid_i && full && !pop_i && !flush_i;
    assign udf_evt = pop_i && empty && !flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = {in_tag_i, in_data_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_en && !pop_en) begin
                level_d = level_q + LW'(1);
            end else if (pop_en && !push_en) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    // Setting beats clearing when both happen in one cycle.
    always_comb begin
        overflow_d  = ovf_evt || (overflow_q && !clr_i);
        underflow_d = udf_evt || (underflow_q && !clr_i);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef QARMA_RESULT_IRQ_EN
    logic irq_q, irq_d;

    // Compared against the next level so irq_o moves in step with level_o.
    always_comb begin
        irq_d = (thresh_i != '0) && (level_d >= thresh_i);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign irq_o         = 1'b0;
`endif

    assign {out_tag_o, out_data_o} = mem_q[rd_ptr_q];
    assign out_valid_o = !empty;
    assign in_ready_o  = !full;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_qarma_result_fifo.sv
// tb/tb_qarma_result_fifo.sv - scoreboard bench for qarma_result_fifo
module tb_qarma_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
    localparam int LW     = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, pop, flush, clr;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic [LW-1:0]     thresh;
    logic              in_ready, out_valid, overflow, underflow, irq;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [LW-1:0]     level;

    int errors = 0;
    int checks = 0;
    logic [TAG_W+DATA_W-1:0] sb [$];
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;

    always #5 clk = ~clk;

    qarma_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .LW(LW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_tag_i   (in_tag),
        .in_ready_o (in_ready),
        .pop_i      (pop),
        .flush_i    (flush),
        .clr_i      (clr),
        .thresh_i   (thresh),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_tag_o  (out_tag),
        .level_o    (level),
        .overflow_o (overflow),
        .underflow_o(underflow),
        .irq_o      (irq)
    );

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must hand out the oldest expected entry.
    always @(negedge clk) begin
        logic [TAG_W+DATA_W-1:0] e;
        if (rst_n && pop && !flush && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %0h expected no entry", {out_tag, out_data});
            end else begin
                e = sb.pop_front();
                if ({out_tag, out_data} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", {out_tag, out_data}, e);
                end
            end
        end
    end

    task automatic check_state(input string tag);
        int  n;
        logic exp_irq;
        n = sb.size();
`ifdef QARMA_RESULT_IRQ_EN
        exp_irq = (thresh != 0) && (n >= int'(thresh));
`else
        exp_irq = 1'b0;
`endif
        chk({tag, "_level"}, DATA_W'(level), DATA_W'(n));
        chk({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(n != 0));
        chk({tag, "_ready"}, DATA_W'(in_ready), DATA_W'(n != DEPTH));
        chk({tag, "_ovf"}, DATA_W'(overflow), DATA_W'(exp_ovf));
        chk({tag, "_udf"}, DATA_W'(underflow), DATA_W'(exp_udf));
        chk({tag, "_irq"}, DATA_W'(irq), DATA_W'(exp_irq));
        if (n != 0) begin
            chk({tag, "_head_data"}, out_data, sb[0][DATA_W-1:0]);
            chk({tag, "_head_tag"}, DATA_W'(out_tag), DATA_W'(sb[0][TAG_W+DATA_W-1:DATA_W]));
        end
    endtask

    // Called #1 after a posedge; applies one cycle of stimulus and updates the model.
    task automatic drive(input string tag, input logic v, input logic [DATA_W-1:0] d,
                         input logic [TAG_W-1:0] t, input logic p, input logic f, input logic c);
        int n;
        n = sb.size();
        in_valid = v; in_data = d; in_tag = t; pop = p; flush = f; clr = c;
        @(posedge clk);
        #1;
        if (f) begin
            sb.delete();
        end else if (v && (n < DEPTH || p)) begin
            sb.push_back({t, d});
        end
        exp_ovf = (!f && v && n == DEPTH && !p) || (exp_ovf && !c);
        exp_udf = (!f && p && n == 0) || (exp_udf && !c);
        in_valid = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
        check_state(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0;
        in_data = '0; in_tag = '0; thresh = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive("push1", 1, 64'h1111_1111_1111_1111, 4'd1, 0, 0, 0);
        drive("push2", 1, 64'h2222_2222_2222_2222, 4'd2, 0, 0, 0);
        drive("push3", 1, 64'h3333_3333_3333_3333, 4'd3, 0, 0, 0);
        chk("three_level", DATA_W'(level), 64'd3);
        chk("three_head", out_data, 64'h1111_1111_1111_1111);
        for (int i = 0; i < 3; i++) drive("pop_in_order", 0, '0, '0, 1, 0, 0);
        chk("drained_valid", DATA_W'(out_valid), 64'd0);

        thresh = 3'd2;
        drive("irq_push1", 1, 64'hAAAA_0000_0000_0001, 4'hA, 0, 0, 0);
        drive("irq_push2", 1, 64'hAAAA_0000_0000_0002, 4'hB, 0, 0, 0);
        drive("irq_pop1", 0, '0, '0, 1, 0, 0);
        drive("irq_pop2", 0, '0, '0, 1, 0, 0);
        thresh = 3'd0;

        drive("push_pop_empty", 1, 64'h7777_7777_7777_7777, 4'd7, 1, 0, 0);
        chk("push_pop_empty_udf", DATA_W'(underflow), 64'd1);
        drive("clr1", 0, '0, '0, 0, 0, 1);
        drive("drain7", 0, '0, '0, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++)
            drive("fill", 1, 64'hC0DE_0000_0000_0000 | 64'(i), 4'(i + 8), 0, 0, 0);
        drive("overflow", 1, 64'hDEAD_DEAD_DEAD_DEAD, 4'hD, 0, 0, 0);
        chk("overflow_flag", DATA_W'(overflow), 64'd1);
        chk("overflow_level", DATA_W'(level), 64'd4);
        drive("full_push_pop", 1, 64'h5555_5555_5555_5555, 4'd5, 1, 0, 0);
        chk("full_push_pop_level", DATA_W'(level), 64'd4);
        for (int i = 0; i < DEPTH; i++) drive("drain_full", 0, '0, '0, 1, 0, 0);

        drive("underflow", 0, '0, '0, 1, 0, 0);
        chk("underflow_flag", DATA_W'(underflow), 64'd1);
        drive("clr_vs_udf", 0, '0, '0, 1, 0, 1);
        chk("clr_set_wins", DATA_W'(underflow), 64'd1);
        drive("clr2", 0, '0, '0, 0, 0, 1);
        chk("clr_ovf", DATA_W'(overflow), 64'd0);
        chk("clr_udf", DATA_W'(underflow), 64'd0);

        drive("pre_flush1", 1, 64'hF1F1_F1F1_F1F1_F1F1, 4'd1, 0, 0, 0);
        drive("pre_flush2", 1, 64'hF2F2_F2F2_F2F2_F2F2, 4'd2, 0, 0, 0);
        drive("flush", 1, 64'hBADD_BADD_BADD_BADD, 4'hE, 1, 1, 0);
        chk("flush_level", DATA_W'(level), 64'd0);

        drive("pre_rst1", 1, 64'h0101_0101_0101_0101, 4'd1, 0, 0, 0);
        drive("pre_rst2", 1, 64'h0202_0202_0202_0202, 4'd2, 0, 0, 0);
        drive("pre_rst3", 1, 64'h0303_0303_0303_0303, 4'd3, 0, 0, 0);
        in_valid = 1'b1; in_data = 64'h0404_0404_0404_0404; in_tag = 4'd4;
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        check_state("async_rst");
        chk("async_rst_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
